// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller state encodings and request FSM states for the
// highway/country traffic signal block.
package traffic_pkg;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        HGRE_CRED = 2'b00,
        HYEL_CRED = 2'b01,
        HRED_CGRE = 2'b10,
        HRED_CYEL = 2'b11
    } ctrl_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        REQ   = 2'b10,
        SERVE = 2'b11
    } req_state_t;

    // Bits needed to hold 0..n, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Debounces the country-road sensor; TRAFFIC_REQ_SYNC_EN adds a 2-flop
// synchronizer ahead of the debounce counter.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sample;
    logic [CW-1:0] cnt;

`ifdef TRAFFIC_REQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = din;
`endif

    // The sample that makes the run DEBOUNCE_CYCLES long flips the level itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sample != dout) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                dout <= ~dout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/traffic_request_gen.sv
// Car-waiting request generator: debounced sensor, minimum highway-green timer
// and request FSM. Optional input synchronizer: TRAFFIC_REQ_SYNC_EN.
module traffic_request_gen
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_HWY_GREEN   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_raw,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    output logic       x,
    output logic       car_waiting,
    output logic       sensor_filt
);

    localparam int unsigned GW = cnt_width(MIN_HWY_GREEN);
    localparam logic [GW-1:0] GREEN_MAX = GW'(MIN_HWY_GREEN);

    logic [GW-1:0] green_cnt;
    req_state_t    state, state_next;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sensor_raw),
        .dout (sensor_filt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            green_cnt <= '0;
        end else if (hwy == LAMP_GREEN) begin
            if (green_cnt != GREEN_MAX) begin
                green_cnt <= green_cnt + 1'b1;
            end
        end else begin
            green_cnt <= '0;
        end
    end

    // Outputs are registered from the next state so they align with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= 1'b0;
            car_waiting <= 1'b0;
        end else begin
            state       <= state_next;
            x           <= (state_next == REQ);
            car_waiting <= (state_next == ARMED) || (state_next == REQ);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (sensor_filt) state_next = ARMED;
            ARMED: begin
                if (green_cnt == GREEN_MAX) begin
                    state_next = REQ;
                end else if (!sensor_filt) begin
                    state_next = IDLE;
                end
            end
            REQ:   if (cntry == LAMP_GREEN) state_next = SERVE;
            SERVE: if (cntry == LAMP_RED && hwy == LAMP_GREEN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_traffic_request_gen.sv
// Scoreboard bench for traffic_request_gen: directed scenarios then random
// stimulus, checked against a behavioural model of the request rules.
module tb_traffic_request_gen;

    localparam int unsigned D   = 4;
    localparam int unsigned MIN = 16;
`ifdef TRAFFIC_REQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    localparam logic [1:0] RED = 2'b00, YEL = 2'b01, GRN = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_raw = 1'b0;
    logic [1:0] hwy = RED;
    logic [1:0] cntry = RED;
    logic       x, car_waiting, sensor_filt;

    typedef struct packed {
        logic x;
        logic cw;
        logic filt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    traffic_request_gen #(
        .DEBOUNCE_CYCLES(D),
        .MIN_HWY_GREEN  (MIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (sensor_raw),
        .hwy        (hwy),
        .cntry      (cntry),
        .x          (x),
        .car_waiting(car_waiting),
        .sensor_filt(sensor_filt)
    );

    always #5 clk = ~clk;

    // Behavioural model: a vehicle request goes through waiting -> requesting
    // -> being served, gated by a filtered sensor and a green-run length.
    bit m_filt = 0;
    int m_diff_run = 0;
    int m_green_run = 0;
    bit m_waiting = 0, m_requesting = 0, m_served = 0;
    bit m_pipe0 = 0, m_pipe1 = 0;

    task automatic model_edge(input bit r, input bit s, input logic [1:0] h, input logic [1:0] c);
        bit smp, old_filt;
        int old_green;
        if (!r) begin
            m_filt = 0; m_diff_run = 0; m_green_run = 0;
            m_waiting = 0; m_requesting = 0; m_served = 0;
            m_pipe0 = 0; m_pipe1 = 0;
            return;
        end
        smp = SYNC ? m_pipe1 : s;
        m_pipe1 = m_pipe0;
        m_pipe0 = s;
        old_filt  = m_filt;
        old_green = m_green_run;
        if (smp != m_filt) begin
            m_diff_run++;
            if (m_diff_run >= D) begin
                m_filt = ~m_filt;
                m_diff_run = 0;
            end
        end else begin
            m_diff_run = 0;
        end
        m_green_run = (h == GRN) ? ((old_green + 1 > MIN) ? MIN : old_green + 1) : 0;
        if (m_served) begin
            if (c == RED && h == GRN) m_served = 0;
        end else if (m_requesting) begin
            if (c == GRN) begin m_requesting = 0; m_served = 1; end
        end else if (m_waiting) begin
            if (old_green >= MIN) begin m_waiting = 0; m_requesting = 1; end
            else if (!old_filt) m_waiting = 0;
        end else if (old_filt) begin
            m_waiting = 1;
        end
    endtask

    task automatic step(input bit r, input bit s, input logic [1:0] h, input logic [1:0] c);
        exp_t e;
        rst_n = r; sensor_raw = s; hwy = h; cntry = c;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(r, s, h, c);
        e.x = m_requesting; e.cw = m_waiting | m_requesting; e.filt = m_filt;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input bit s, input logic [1:0] h, input logic [1:0] c);
        for (int i = 0; i < n; i++) step(1'b1, s, h, c);
    endtask

    task automatic check_out(input string name, input logic ex, input logic ecw, input logic efilt);
        tests_run++;
        if (x !== ex || car_waiting !== ecw || sensor_filt !== efilt) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got x=%b car_waiting=%b sensor_filt=%b expected x=%b car_waiting=%b sensor_filt=%b",
                     name, cyc, x, car_waiting, sensor_filt, ex, ecw, efilt);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (x !== e.x || car_waiting !== e.cw || sensor_filt !== e.filt) begin
                tests_failed++;
                $display("FAIL outputs cyc=%0d got x=%b car_waiting=%b sensor_filt=%b expected x=%b car_waiting=%b sensor_filt=%b",
                         cyc, x, car_waiting, sensor_filt, e.x, e.cw, e.filt);
            end
        end
    end

    initial begin
        int seg_s, seg_h;
        bit s_val;
        logic [1:0] h_val, c_val;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, RED, RED);
        check_out("reset_state", 1'b0, 1'b0, 1'b0);

        // Glitch rejection: 3-cycle pulse during long green.
        run(20, 1'b0, GRN, RED);
        run(3, 1'b1, GRN, RED);
        run(10, 1'b0, GRN, RED);

        // Basic request, served, then release.
        run(12, 1'b1, GRN, RED);
        run(2, 1'b0, YEL, RED);
        run(3, 1'b0, RED, GRN);
        run(2, 1'b0, RED, YEL);
        run(4, 1'b0, GRN, RED);

        // Minimum green with sensor already stable at 1.
        run(8, 1'b1, RED, RED);
        run(22, 1'b1, GRN, RED);
        check_out("expired_wait", 1'b1, 1'b1, 1'b1);
        run(2, 1'b1, RED, GRN);
        run(3, 1'b1, GRN, RED);   // re-arms immediately while still present
        run(6, 1'b0, GRN, RED);

        // Vehicle leaves while armed (green not yet long enough).
        run(3, 1'b0, RED, RED);
        run(8, 1'b1, GRN, RED);
        run(8, 1'b0, GRN, RED);
        run(6, 1'b0, GRN, RED);

        // Vehicle leaves while requesting: request holds until country green.
        run(25, 1'b0, GRN, RED);
        run(8, 1'b1, GRN, RED);
        run(8, 1'b0, GRN, RED);
        run(2, 1'b0, RED, GRN);
        run(3, 1'b0, GRN, RED);

        // Reset mid-request, then the request re-forms.
        run(25, 1'b1, GRN, RED);
        step(1'b0, 1'b1, GRN, RED);
        check_out("reset_mid_req", 1'b0, 1'b0, 1'b0);
        run(25, 1'b1, GRN, RED);
        run(2, 1'b1, RED, GRN);
        run(3, 1'b0, GRN, RED);

        // Random traffic.
        seg_s = 0; seg_h = 0; s_val = 0; h_val = GRN; c_val = RED;
        for (int i = 0; i < 3000; i++) begin
            if (seg_s == 0) begin
                seg_s = $urandom_range(1, 10);
                s_val = $urandom_range(0, 1);
            end
            if (seg_h == 0) begin
                seg_h = $urandom_range(1, 24);
                case ($urandom_range(0, 9))
                    0, 1:    begin h_val = RED; c_val = GRN; end
                    2:       begin h_val = YEL; c_val = RED; end
                    3:       begin h_val = RED; c_val = YEL; end
                    default: begin h_val = GRN; c_val = RED; end
                endcase
            end
            seg_s--; seg_h--;
            step(($urandom_range(0, 299) != 0), s_val, h_val, c_val);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
